// File: rtl/exception_commit_ctrl.sv
// Commit sequencer for a resolved MEM-stage exception or ERET: one CP0 update pulse,
// a fixed-length pipeline flush, then a valid/ready redirect to IF. Optional macro: BADVADDR_EN.
module exception_commit_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'hBFC0_0380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_valid_i,
  input  logic        exc_is_eret_i,
  input  logic [4:0]  exc_code_i,
  input  logic [31:0] exc_pc_i,
  input  logic        exc_bd_i,
  input  logic [31:0] exc_badvaddr_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cp0_exl_i,
  input  logic        redirect_ready_i,
  output logic        busy_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        cp0_we_o,
  output logic        cp0_epc_we_o,
  output logic [31:0] cp0_epc_o,
  output logic        cp0_bd_o,
  output logic [4:0]  cp0_exccode_o,
  output logic        cp0_exl_set_o,
  output logic        cp0_exl_clr_o
`ifdef BADVADDR_EN
  ,
  output logic        cp0_badvaddr_we_o,
  output logic [31:0] cp0_badvaddr_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_e;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        eret_q;
  logic [31:0] epc_fwd_q;
  logic        busy_q, flush_q, rv_q;
  logic [31:0] rpc_q;
  logic        we_q, epc_we_q, bd_q, exl_set_q, exl_clr_q;
  logic [31:0] epc_q;
  logic [4:0]  code_q;
`ifdef BADVADDR_EN
  logic        bva_we_q;
  logic [31:0] bva_q;
`else
  logic        unused_badvaddr;
  assign unused_badvaddr = ^exc_badvaddr_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      eret_q    <= 1'b0;
      epc_fwd_q <= '0;
      busy_q    <= 1'b0;
      flush_q   <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
      we_q      <= 1'b0;
      epc_we_q  <= 1'b0;
      epc_q     <= '0;
      bd_q      <= 1'b0;
      code_q    <= '0;
      exl_set_q <= 1'b0;
      exl_clr_q <= 1'b0;
`ifdef BADVADDR_EN
      bva_we_q  <= 1'b0;
      bva_q     <= '0;
`endif
    end else begin
      // CP0 fields are only meaningful during the single-cycle strobe
      we_q      <= 1'b0;
      epc_we_q  <= 1'b0;
      epc_q     <= '0;
      bd_q      <= 1'b0;
      code_q    <= '0;
      exl_set_q <= 1'b0;
      exl_clr_q <= 1'b0;
`ifdef BADVADDR_EN
      bva_we_q  <= 1'b0;
`endif
      unique case (state_q)
        S_IDLE: begin
          if (exc_valid_i) begin
            state_q   <= S_FLUSH;
            cnt_q     <= CNT_INIT;
            busy_q    <= 1'b1;
            flush_q   <= 1'b1;
            eret_q    <= exc_is_eret_i;
            epc_fwd_q <= cp0_epc_i;
            we_q      <= 1'b1;
`ifdef BADVADDR_EN
            bva_q     <= exc_badvaddr_i;
`endif
            if (exc_is_eret_i) begin
              exl_clr_q <= 1'b1;
            end else begin
              exl_set_q <= 1'b1;
              epc_we_q  <= ~cp0_exl_i;
              epc_q     <= exc_bd_i ? exc_pc_i - 32'd4 : exc_pc_i;
              bd_q      <= exc_bd_i;
              code_q    <= exc_code_i;
`ifdef BADVADDR_EN
              bva_we_q  <= (exc_code_i == 5'd4) || (exc_code_i == 5'd5);
`endif
            end
          end
        end
        S_FLUSH: begin
          if (cnt_q == '0) begin
            state_q <= S_REDIRECT;
            flush_q <= 1'b0;
            rv_q    <= 1'b1;
            rpc_q   <= eret_q ? epc_fwd_q : EXC_VECTOR;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready_i) begin
            state_q <= S_IDLE;
            rv_q    <= 1'b0;
            rpc_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign flush_o          = flush_q;
  assign redirect_valid_o = rv_q;
  assign redirect_pc_o    = rpc_q;
  assign cp0_we_o         = we_q;
  assign cp0_epc_we_o     = epc_we_q;
  assign cp0_epc_o        = epc_q;
  assign cp0_bd_o         = bd_q;
  assign cp0_exccode_o    = code_q;
  assign cp0_exl_set_o    = exl_set_q;
  assign cp0_exl_clr_o    = exl_clr_q;
`ifdef BADVADDR_EN
  assign cp0_badvaddr_we_o = bva_we_q;
  assign cp0_badvaddr_o    = bva_q;
`endif

endmodule
